ws2811_serialiser: RTL and testbench

- Output stage between ledcontroller and the physical WS2811 data line.
- Drives ledindex to ledcontroller and samples the red/green/blue bytes it returns.
- Encodes each pixel as a 24-bit NRZ pulse-width stream (GRB order, MSB first) and closes every frame with a latch (low) period.
- Free-running, with no backpressure. Update rate is set by the timing parameters.

---
 rtl/ws2811_pkg.sv | 41 ++++
 rtl/ws2811_bittimer.sv | 56 +++++
 rtl/ws2811_serialiser.sv | 154 +++++++++++++++
 tb/tb_ws2811_serialiser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// Shared WS2811 types, 12 MHz default timing and GRB packing for the serialiser.
// Latency: n/a (declarations only); backpressure: n/a.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_BITHI = 3'd3,
        ST_BITLO = 3'd4
    } state_t;

    localparam int DEF_NUM_LEDS = 54;
    localparam int DEF_T0H      = 4;
    localparam int DEF_T1H      = 9;
    localparam int DEF_TBIT     = 15;
    localparam int DEF_TRESET   = 1000;

    localparam int CNT_W    = 16;
    localparam int BITCNT_W = 5;
    localparam int PIX_W    = 24;

    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    function automatic logic [PIX_W-1:0] pack_grb(input logic [7:0] g,
                                                  input logic [7:0] r,
                                                  input logic [7:0] b);
        logic [PIX_W-1:0] p;
        p              = '0;
        p[G_MSB:G_LSB] = g;
        p[R_MSB:R_LSB] = r;
        p[B_MSB:B_LSB] = b;
        return p;
    endfunction

endpackage

// File: rtl/ws2811_bittimer.sv
// One NRZ bit: start_i -> dout high T0H/T1H cycles, then low to TBIT total; done_o on last cycle.
// Latency: dout rises the cycle after start_i; backpressure: none, start_i may coincide with done_o.
module ws2811_bittimer
    import ws2811_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    input  logic bit_i,
    output logic dout_o,
    output logic hi_end_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] T0H_C     = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] T1H_C     = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT - 1);

    logic             active_q;
    logic             dout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hilen_q;

    assign hi_end_o = active_q && dout_q && (cnt_q == hilen_q - CNT_W'(1));
    assign done_o   = active_q && (cnt_q == TBIT_LAST);
    assign dout_o   = dout_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            dout_q   <= 1'b0;
            cnt_q    <= '0;
            hilen_q  <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            dout_q   <= 1'b1;
            cnt_q    <= '0;
            hilen_q  <= bit_i ? T1H_C : T0H_C;
        end else if (active_q) begin
            if (done_o) begin
                active_q <= 1'b0;
                dout_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (hi_end_o) begin
                    dout_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ws2811_serialiser.sv
// Drives ledindex, samples GRB per pixel, emits WS2811 NRZ stream and a TRESET latch per frame.
// Latency: first dout rise TRESET+1 cycles after framesync; backpressure: none, free-running.
module ws2811_serialiser
    import ws2811_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRESET   = DEF_TRESET
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] ledindex,
    output logic       dout,
    output logic       framesync,
    output logic       busy
);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_bit_timing
        $error("ws2811_serialiser: need 0 < T0H < T1H < TBIT");
    end
    if (TBIT * 24 < 48 || TRESET < 48) begin : g_bad_settle_timing
        $error("ws2811_serialiser: ledcontroller settle window needs TBIT*24 >= 48 and TRESET >= 48");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_num_leds
        $error("ws2811_serialiser: NUM_LEDS must be 1..256");
    end

    localparam logic [7:0]       LAST_IDX = 8'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(TRESET - 1);

    state_t              state_q, state_d;
    logic [PIX_W-1:0]    shreg_q, shreg_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          ledindex_q, ledindex_d;
    logic                framesync_q, framesync_d;
    logic                busy_q;

    logic tmr_start;
    logic tmr_bit;
    logic tmr_dout;
    logic tmr_hi_end;
    logic tmr_done;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        cnt_d       = cnt_q;
        ledindex_d  = ledindex_q;
        framesync_d = 1'b0;
        tmr_start   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d     = ST_LATCH;
                    framesync_d = 1'b1;
                    cnt_d       = '0;
                    ledindex_d  = '0;
                end
            end
            ST_LATCH: begin
                if (cnt_q == RST_LAST) begin
                    state_d = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                shreg_d    = pack_grb(green, red, blue);
                ledindex_d = (ledindex_q == LAST_IDX) ? 8'd0 : ledindex_q + 8'd1;
                bitcnt_d   = BITCNT_W'(PIX_W - 1);
                tmr_start  = 1'b1;
                state_d    = ST_BITHI;
            end
            ST_BITHI: begin
                if (tmr_hi_end) begin
                    state_d = ST_BITLO;
                end
            end
            ST_BITLO: begin
                if (tmr_done) begin
                    if (bitcnt_q != '0) begin
                        // Rotating instead of shifting is harmless: the wrapped bit is reloaded before it reaches bit 23.
                        shreg_d   = {shreg_q[PIX_W-2:0], shreg_q[PIX_W-1]};
                        bitcnt_d  = bitcnt_q - BITCNT_W'(1);
                        tmr_start = 1'b1;
                        state_d   = ST_BITHI;
                    end else if (ledindex_q == 8'd0 || !enable) begin
                        // ledindex already wrapped to 0 in LOAD when the pixel just sent was the last one.
                        state_d     = ST_LATCH;
                        framesync_d = 1'b1;
                        cnt_d       = '0;
                        ledindex_d  = '0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmr_bit = shreg_d[PIX_W-1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            ledindex_q  <= '0;
            framesync_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            cnt_q       <= cnt_d;
            ledindex_q  <= ledindex_d;
            framesync_q <= framesync_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    ws2811_bittimer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bittimer (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (tmr_start),
        .bit_i    (tmr_bit),
        .dout_o   (tmr_dout),
        .hi_end_o (tmr_hi_end),
        .done_o   (tmr_done)
    );

    assign ledindex  = ledindex_q;
    assign dout      = tmr_dout;
    assign framesync = framesync_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ws2811_serialiser.sv
// Scoreboarded bench: stimulus queues expected pixel/framesync events, a dout decoder pops and compares.
// A second NUM_LEDS=1 instance checks frame period and index pinning.
module tb_ws2811_serialiser;

    localparam int T0H    = 2;
    localparam int T1H    = 5;
    localparam int TBIT   = 8;
    localparam int TRESET = 60;
    localparam logic [24:0] FS_EV = {1'b1, 24'h000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, enable, en1;
    logic [7:0] red0, red1, ledindex0, ledindex1;
    logic       dout0, fs0, busy0, dout1, fs1, busy1;

    // ledcontroller stand-in: red follows ledindex 44 cycles late
    logic [7:0] pipe0 [44];
    logic [7:0] pipe1 [44];
    always @(posedge clk) begin
        pipe0[0] <= ledindex0;
        pipe1[0] <= ledindex1;
        for (int i = 1; i < 44; i++) begin
            pipe0[i] <= pipe0[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign red0 = pipe0[43];
    assign red1 = pipe1[43];

    ws2811_serialiser #(
        .NUM_LEDS(3), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .red(red0), .green(8'hA5), .blue(8'hFF),
        .ledindex(ledindex0), .dout(dout0), .framesync(fs0), .busy(busy0)
    );

    ws2811_serialiser #(
        .NUM_LEDS(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut1 (
        .clk(clk), .resetn(resetn), .enable(en1),
        .red(red1), .green(8'hA5), .blue(8'hFF),
        .ledindex(ledindex1), .dout(dout1), .framesync(fs1), .busy(busy1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [24:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input string name, input logic [24:0] act);
        logic [24:0] e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0h, want nothing (scoreboard empty, cycle %0d)", name, act, cyc);
        end else begin
            e = sb.pop_front();
            chk(name, int'(act), int'(e));
        end
    endtask

    function automatic logic [24:0] pix(input logic [7:0] idx);
        return {1'b0, 8'hA5, idx, 8'hFF};
    endfunction

    task automatic wait_fs(input bit which, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which ? fs1 : fs0) === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL fs_timeout: got no framesync, want one within %0d cycles", limit);
        end
    endtask

    // Monitor: decodes dout0 into bits and pixels, checks timing, pops the scoreboard
    int          hi_w = 0, bitn = 0, fs_cyc = 0, prev_rise = 0;
    bit          prev_d = 1'b0, have_rise = 1'b0, after_fs = 1'b0, fs_prev = 1'b0, b;
    logic [23:0] acc = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_d    = 1'b0;
            hi_w      = 0;
            bitn      = 0;
            acc       = '0;
            have_rise = 1'b0;
            after_fs  = 1'b0;
            fs_prev   = 1'b0;
        end else begin
            if (fs0) begin
                chk("fs_width", int'(fs_prev), 0);
                chk("fs_bit_align", bitn, 0);
                sb_pop("fs_event", FS_EV);
                fs_cyc   = cyc;
                after_fs = 1'b1;
            end
            if (dout0 && !prev_d) begin
                if (after_fs)
                    chk("latch_gap", cyc - fs_cyc, TRESET + 1);
                else if (have_rise)
                    chk("bit_period", cyc - prev_rise, (bitn == 0) ? TBIT + 1 : TBIT);
                after_fs  = 1'b0;
                have_rise = 1'b1;
                prev_rise = cyc;
                hi_w      = 1;
            end else if (dout0) begin
                hi_w++;
            end
            if (!dout0 && prev_d) begin
                b = (hi_w > 3);
                chk("hi_width", hi_w, b ? T1H : T0H);
                acc = {acc[22:0], b};
                bitn++;
                if (bitn == 24) begin
                    sb_pop("pixel", {1'b0, acc});
                    bitn = 0;
                end
            end
            prev_d  = dout0;
            fs_prev = fs0;
        end
    end

    bit li1_bad = 1'b0;
    always @(negedge clk) if (resetn === 1'b1 && ledindex1 !== 8'd0) li1_bad = 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, want $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_a, fs_b, rise_t, t, highs;
        resetn = 1'b0;
        enable = 1'b0;
        en1    = 1'b0;

        // Phase 1: full frame, second frame disabled mid pixel 1
        sb.push_back(FS_EV);
        sb.push_back(pix(8'd0));
        sb.push_back(pix(8'd1));
        sb.push_back(pix(8'd2));
        sb.push_back(FS_EV);
        sb.push_back(pix(8'd0));
        sb.push_back(pix(8'd1));
        sb.push_back(FS_EV);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout0), 0);
        chk("rst_ledindex", int'(ledindex0), 0);
        chk("rst_framesync", int'(fs0), 0);
        chk("rst_busy", int'(busy0), 0);
        resetn = 1'b1;
        enable = 1'b1;

        wait_fs(1'b0, 10, fs_a);
        wait_fs(1'b0, 700, fs_b);
        chk("frame_len", fs_b - fs_a, 639);
        repeat (336) @(negedge clk);
        enable = 1'b0;
        fs_a = fs_b;
        wait_fs(1'b0, 500, fs_b);
        chk("disable_len", fs_b - fs_a, 446);
        repeat (59) @(negedge clk);
        chk("busy_latch_end", int'(busy0), 1);
        @(negedge clk);
        chk("busy_idle", int'(busy0), 0);
        chk("dout_idle", int'(dout0), 0);
        repeat (100) @(negedge clk);
        chk("still_idle", int'(busy0), 0);

        // Phase 2: reset during the high part of the first '1' bit
        sb.push_back(FS_EV);
        enable = 1'b1;
        wait_fs(1'b0, 10, fs_a);
        rise_t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dout0 === 1'b1) begin
                rise_t = cyc;
                break;
            end
        end
        chk("first_rise_seen", int'(rise_t >= 0), 1);
        @(posedge clk);
        #1;
        chk("bithi_before_reset", int'(dout0), 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midbit_rst_dout", int'(dout0), 0);
        chk("midbit_rst_ledindex", int'(ledindex0), 0);
        chk("midbit_rst_framesync", int'(fs0), 0);
        chk("midbit_rst_busy", int'(busy0), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb.push_back(FS_EV);
        sb.push_back(pix(8'd0));
        sb.push_back(pix(8'd1));
        sb.push_back(pix(8'd2));
        sb.push_back(FS_EV);
        wait_fs(1'b0, 10, fs_a);
        repeat (456) @(negedge clk);
        enable = 1'b0;
        wait_fs(1'b0, 400, fs_b);
        chk("frame_len2", fs_b - fs_a, 639);
        repeat (61) @(negedge clk);
        chk("busy_idle2", int'(busy0), 0);

        // Phase 3: single-LED instance
        en1 = 1'b1;
        wait_fs(1'b1, 10, fs_a);
        for (int k = 0; k < 3; k++) begin
            highs = 0;
            t = -1;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (fs1 === 1'b1) begin
                    t = cyc;
                    break;
                end
                if (dout1 === 1'b1) highs++;
            end
            chk("fs1_period", t - fs_a, 253);
            chk("frame1_highs", highs, 84);
            fs_a = t;
        end
        en1 = 1'b0;
        repeat (300) @(negedge clk);
        chk("busy1_idle", int'(busy1), 0);
        chk("ledindex1_stays_0", int'(li1_bad), 0);

        chk("sb_empty", sb.size(), 0);
        chk("partial_bits", bitn, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
